rf_write_arbiter: RTL

Shares the register file's single write port between the non-stallable writeback stage and the multi-cycle multdiv unit. Multdiv results are held in a small FIFO and drained only on cycles where writeback does not write. The block drives the write enable, the 5-bit write select (which feeds the codebase's decoder32) and the write data. It also exports a pending-write mask so hazard logic can stall readers of registers that still have a buffered write.

---
 rtl/rf_write_arbiter_pkg.sv | 21 ++
 rtl/rf_write_arbiter_if.sv | 40 ++++
 rtl/decoder32.sv | 21 ++
 rtl/rf_write_arbiter_md_result_fifo.sv | 84 ++++++++
 rtl/rf_write_arbiter.sv | 110 +++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared constants and types for the register-file write arbiter slice.
//   REG_ADDR_W   : width of a register select (decoder32 select)
//   NUM_REGS     : number of architectural registers
//   ENTRY_DATA_W : data width carried by a buffered multdiv result
//   md_entry_t   : one multdiv result FIFO entry {live, addr, data}
// ---------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned ENTRY_DATA_W = 32;

    typedef struct packed {
        logic                    live;
        logic [REG_ADDR_W-1:0]   addr;
        logic [ENTRY_DATA_W-1:0] data;
    } md_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the writeback request, the multdiv result handshake and the
// register-file write port.
//   wb_valid/wb_addr/wb_data    : writeback write request (never stalled)
//   md_valid/md_addr/md_data    : multdiv result, accepted when md_ready
//   md_ready                    : arbiter FIFO can accept a result
//   rf_we/rf_waddr/rf_wdata     : registered register-file write port
//   pending                     : per-register mask of buffered live writes
// master = producer side (pipeline), slave = the arbiter.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0]     md_data;
    logic                  md_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [NUM_REGS-1:0]   pending;

    modport master (
        output wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
        input  md_ready, rf_we, rf_waddr, rf_wdata, pending
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
        output md_ready, rf_we, rf_waddr, rf_wdata, pending
    );

endinterface

// File: rtl/decoder32.sv
// ---------------------------------------------------------------------------
// decoder32
// 5-to-32 one-hot decoder with enable.
//   sel : register select
//   en  : when low, all outputs are 0
//   y   : one-hot decode of sel
// ---------------------------------------------------------------------------
module decoder32 (
    input  logic [4:0]  sel,
    input  logic        en,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter_md_result_fifo.sv
// ---------------------------------------------------------------------------
// md_result_fifo
// Buffers multdiv results until the register-file port is free.
//   clk, rst        : clock, asynchronous active-high reset
//   push/push_entry : store an entry (ignored when full)
//   pop             : retire the head entry (ignored when empty)
//   kill/kill_addr  : mark every stored entry targeting kill_addr dead
//   head            : entry at the read pointer
//   count/full/empty: occupancy
//   live/addr       : per-slot view used to build the pending mask
// ---------------------------------------------------------------------------
module md_result_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  md_entry_t                       push_entry,
    input  logic                            pop,
    input  logic                            kill,
    input  logic [REG_ADDR_W-1:0]           kill_addr,
    output md_entry_t                       head,
    output logic [PTR_W:0]                  count,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                live,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] addr
);

    localparam int unsigned CNT_W = PTR_W + 1;

    md_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_comb begin
        live = '0;
        addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live[i] = mem[i].live;
            addr[i] = mem[i].addr;
        end
    end

    // Kill only sees entries already stored; the pushed entry is written
    // afterwards in the same block so a same-edge push to kill_addr stays live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].live && (mem[i].addr == kill_addr)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (do_pop) begin
                mem[rptr].live <= 1'b0;
                rptr           <= rptr + 1'b1;
            end
            if (do_push) begin
                mem[wptr] <= push_entry;
                wptr      <= wptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register-file write port between writeback (highest priority,
// never stalled) and buffered multdiv results drained on wb-free cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rf_write_arbiter_if.slave (wb request, md handshake,
//              registered rf write port, pending mask)
// Parameters: DEPTH (power of 2, >= 2), DATA_W (register data width).
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DATA_W == 0 || DATA_W > ENTRY_DATA_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("rf_write_arbiter: unsupported DEPTH/DATA_W");
    end

    logic                            wb_write;
    logic                            push;
    logic                            pop;
    md_entry_t                       push_entry;
    md_entry_t                       head;
    logic [PTR_W:0]                  count;
    logic                            full;
    logic                            empty;
    logic [DEPTH-1:0]                live;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr;
    logic [NUM_REGS-1:0]             dec [DEPTH];

    // Register 0 is never written: treat such requests as absent.
    assign wb_write     = bus.wb_valid && (bus.wb_addr != '0);
    assign push         = bus.md_valid && bus.md_ready && (bus.md_addr != '0);
    assign pop          = !wb_write && !empty;
    assign bus.md_ready = !rst && !full;

    always_comb begin
        push_entry      = '0;
        push_entry.live = 1'b1;
        push_entry.addr = bus.md_addr;
        push_entry.data = ENTRY_DATA_W'(bus.md_data);
    end

    md_result_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (wb_write),
        .kill_addr  (bus.wb_addr),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .live       (live),
        .addr       (addr)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_dec
        decoder32 u_dec (
            .sel (addr[g]),
            .en  (live[g]),
            .y   (dec[g])
        );
    end

    always_comb begin
        bus.pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.pending = bus.pending | dec[i];
        end
    end

    // A popped dead head leaves the port idle for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else if (wb_write) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.wb_addr;
            bus.rf_wdata <= bus.wb_data;
        end else if (pop && head.live) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= head.addr;
            bus.rf_wdata <= head.data[DATA_W-1:0];
        end else begin
            bus.rf_we    <= 1'b0;
        end
    end

    property p_full_matches_count;
        @(posedge clk) disable iff (rst) full == (count == (PTR_W + 1)'(DEPTH));
    endproperty
    assert property (p_full_matches_count);

endmodule
